// File: rtl/bus_master_if_if.sv
// Core-side command/response and shared-bus master-port signals for bus_master_if.
// The master modport is the adapter's view; slave is the core/arbiter/slave side.
interface bus_master_if_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  // core command / response
  logic              req_valid;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wr_data;
  logic              busy;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rd_data;
  logic              resp_err;

  // shared bus master port
  logic              bus_req;
  logic              bus_grnt;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic              bus_rdy;
  logic [DATA_W-1:0] bus_rd_data;

  modport master (
    input  req_valid, req_rw, req_addr, req_wr_data,
    input  bus_grnt, bus_rdy, bus_rd_data,
    output busy, resp_valid, resp_rd_data, resp_err,
    output bus_req, bus_addr, bus_as_, bus_rw, bus_wr_data
  );

  modport slave (
    output req_valid, req_rw, req_addr, req_wr_data,
    output bus_grnt, bus_rdy, bus_rd_data,
    input  busy, resp_valid, resp_rd_data, resp_err,
    input  bus_req, bus_addr, bus_as_, bus_rw, bus_wr_data
  );
endinterface

// File: rtl/bus_master_if.sv
// Single-outstanding bus initiator: request/grant, one-cycle address strobe, wait for ready.
// Optional WAIT-state timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_if #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             rest,
  bus_master_if_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] WAIT   = 2'd3;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("bus_master_if: TIMEOUT_CYC must be 1..255");
  end

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
  } cmd_t;

  logic [1:0]        state;
  cmd_t              cmd;
  logic              req_q;
  logic              as_n_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              done;

  // ready only counts during the data phase; elsewhere it is ignored
  assign done = ((state == ACCESS) || (state == WAIT)) && bus.bus_rdy;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] to_cnt;
  logic       err_q;
  logic       expire;

  // counter holds the number of rdy-low WAIT cycles already elapsed
  assign expire = (state == WAIT) && !bus.bus_rdy && (to_cnt == TO_LAST);
`endif

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state        <= IDLE;
      cmd.rw       <= 1'b1;
      cmd.addr     <= '0;
      cmd.wr_data  <= '0;
      req_q        <= 1'b0;
      as_n_q       <= 1'b1;
      resp_valid_q <= 1'b0;
      rd_data_q    <= '0;
`ifdef BUS_MASTER_TIMEOUT_EN
      to_cnt       <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cmd.rw      <= bus.req_rw;
            cmd.addr    <= bus.req_addr;
            cmd.wr_data <= bus.req_wr_data;
            req_q       <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_grnt) begin
            as_n_q <= 1'b0;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          as_n_q <= 1'b1;
          if (!done) begin
            state <= WAIT;
`ifdef BUS_MASTER_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        WAIT: begin
`ifdef BUS_MASTER_TIMEOUT_EN
          if (expire) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            rd_data_q    <= '0;
            err_q        <= 1'b1;
          end else if (!done) begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase

      // normal completion shared by ACCESS and WAIT; ready beats a same-cycle expiry
      if (done) begin
        state        <= IDLE;
        req_q        <= 1'b0;
        as_n_q       <= 1'b1;
        resp_valid_q <= 1'b1;
        if (cmd.rw) rd_data_q <= bus.bus_rd_data;
`ifdef BUS_MASTER_TIMEOUT_EN
        err_q        <= 1'b0;
`endif
      end
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rd_data = rd_data_q;
  assign bus.bus_req      = req_q;
  assign bus.bus_as_      = as_n_q;
  assign bus.bus_rw       = cmd.rw;
  assign bus.bus_addr     = cmd.addr;
  assign bus.bus_wr_data  = cmd.wr_data;
`ifdef BUS_MASTER_TIMEOUT_EN
  assign bus.resp_err     = err_q;
`else
  assign bus.resp_err     = 1'b0;
`endif

endmodule
